// File: rtl/sequenciador_execucao.sv
// sequenciador_execucao: multi-cycle instruction sequencer for the LabSO processor.
// It paces each instruction through a fetch (BUSCA) cycle and an EXEC_CYCLES-long execute
// phase, and gates the PC advance and the register-file write. It stalls on `in` until the
// confirm button is pressed, then latches the switches. It also stalls on `pause` and
// freezes for good on END.
//
// Ports:
//   clock, reset            - rising-edge clock, asynchronous active-low reset
//   opcode, status          - decoder opcode and stall request
//   escritaRegIn            - decoder register-write request
//   entradaSaidaControl     - decoder I/O selector (01 = out)
//   confirma                - raw, asynchronous confirm pushbutton
//   chaves                  - raw switch bank (static while the operator confirms)
//   dadoSaida               - register value shown by `out`
//   habilitaPC, escritaReg  - one-cycle PC-advance and register-write pulses
//   dadoEntrada             - latched, zero-extended switches
//   display                 - latched `out` value
//   aguardando, parado      - waiting for the operator / halted
//   estado                  - current state code
module sequenciador_execucao #(
  parameter int unsigned EXEC_CYCLES = 2,
  parameter int unsigned WIDTH_IN    = 16,
  parameter int unsigned WIDTH_DADO  = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [5:0]            opcode,
  input  logic                  status,
  input  logic                  escritaRegIn,
  input  logic [1:0]            entradaSaidaControl,
  input  logic                  confirma,
  input  logic [WIDTH_IN-1:0]   chaves,
  input  logic [WIDTH_DADO-1:0] dadoSaida,
  output logic                  habilitaPC,
  output logic                  escritaReg,
  output logic [WIDTH_DADO-1:0] dadoEntrada,
  output logic [WIDTH_DADO-1:0] display,
  output logic                  aguardando,
  output logic                  parado,
  output logic [2:0]            estado
);

  typedef enum logic [2:0] {
    StBusca   = 3'd0,
    StExecuta = 3'd1,
    StEspera  = 3'd2,
    StEscreve = 3'd3,
    StPausa   = 3'd4,
    StFim     = 3'd5
  } estado_e;

  localparam logic [5:0] OpEnd   = 6'b011111;
  localparam logic [5:0] OpIn    = 6'b011101;
  localparam logic [1:0] EsOut   = 2'b01;
  localparam logic [3:0] CntLast = 4'(EXEC_CYCLES - 1);

  estado_e               state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  sync1_q, sync2_q, prev_q;
  logic [WIDTH_DADO-1:0] dado_entrada_q, dado_entrada_d;
  logic [WIDTH_DADO-1:0] display_q, display_d;

  logic confirm_edge;
  logic last_exec;
  logic commit;

  // The prev register turns a held button into exactly one edge.
  assign confirm_edge = sync2_q & ~prev_q;
  assign last_exec    = (state_q == StExecuta) && (cnt_q == CntLast);
  // A normal instruction retires on its last execute cycle unless it halts or stalls.
  assign commit       = last_exec && (opcode != OpEnd) && !status;

  always_comb begin
    state_d        = state_q;
    cnt_d          = 4'd0;
    dado_entrada_d = dado_entrada_q;
    display_d      = display_q;
    case (state_q)
      StBusca: begin
        state_d = StExecuta;
      end
      StExecuta: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == CntLast) begin
          if (opcode == OpEnd) begin
            state_d = StFim;
          end else if (status && (opcode == OpIn)) begin
            state_d = StEspera;
          end else if (status) begin
            state_d = StPausa;
          end else begin
            state_d = StBusca;
            if (entradaSaidaControl == EsOut) begin
              display_d = dadoSaida;
            end
          end
        end
      end
      StEspera: begin
        if (confirm_edge) begin
          dado_entrada_d = WIDTH_DADO'(chaves);
          state_d        = StEscreve;
        end
      end
      StEscreve: begin
        state_d = StBusca;
      end
      StPausa: begin
        if (confirm_edge) begin
          state_d = StBusca;
        end
      end
      StFim: begin
        state_d = StFim;
      end
      // Unused codes 6 and 7 fall back to fetch.
      default: begin
        state_d = StBusca;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q        <= StBusca;
      cnt_q          <= 4'd0;
      sync1_q        <= 1'b0;
      sync2_q        <= 1'b0;
      prev_q         <= 1'b0;
      dado_entrada_q <= '0;
      display_q      <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      sync1_q        <= confirma;
      sync2_q        <= sync1_q;
      prev_q         <= sync2_q;
      dado_entrada_q <= dado_entrada_d;
      display_q      <= display_d;
    end
  end

  always_comb begin
    habilitaPC = commit || (state_q == StEscreve) || ((state_q == StPausa) && confirm_edge);
    escritaReg = (commit && escritaRegIn) || (state_q == StEscreve);
    aguardando = (state_q == StEspera) || (state_q == StPausa);
    parado     = (state_q == StFim);
    estado     = state_q;
  end

  assign dadoEntrada = dado_entrada_q;
  assign display     = display_q;

endmodule

// File: tb/tb_sequenciador_execucao.sv
// Directed bench for sequenciador_execucao at default parameters (EXEC_CYCLES=2).
// Inputs change 2 time units after a rising edge; outputs are checked at that point.
module tb_sequenciador_execucao;

  logic        clock = 1'b0;
  logic        reset;
  logic [5:0]  opcode;
  logic        status;
  logic        escritaRegIn;
  logic [1:0]  entradaSaidaControl;
  logic        confirma;
  logic [15:0] chaves;
  logic [31:0] dadoSaida;
  logic        habilitaPC;
  logic        escritaReg;
  logic [31:0] dadoEntrada;
  logic [31:0] display;
  logic        aguardando;
  logic        parado;
  logic [2:0]  estado;

  int n_assert = 0;
  int n_fail   = 0;

  sequenciador_execucao #(
    .EXEC_CYCLES(2),
    .WIDTH_IN   (16),
    .WIDTH_DADO (32)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .opcode             (opcode),
    .status             (status),
    .escritaRegIn       (escritaRegIn),
    .entradaSaidaControl(entradaSaidaControl),
    .confirma           (confirma),
    .chaves             (chaves),
    .dadoSaida          (dadoSaida),
    .habilitaPC         (habilitaPC),
    .escritaReg         (escritaReg),
    .dadoEntrada        (dadoEntrada),
    .display            (display),
    .aguardando         (aguardando),
    .parado             (parado),
    .estado             (estado)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected end of test");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input string tag, input logic [2:0] st, input logic hab, input logic esc);
    chk({tag, ".estado"}, 32'(estado), 32'(st));
    chk({tag, ".habilitaPC"}, 32'(habilitaPC), 32'(hab));
    chk({tag, ".escritaReg"}, 32'(escritaReg), 32'(esc));
  endtask

  task automatic wait_state(input logic [2:0] st, input int budget, input string tag);
    int n = 0;
    while (estado !== st && n < budget) begin
      tick();
      n++;
    end
    chk(tag, 32'(estado), 32'(st));
  endtask

  initial begin
    int nw, ne, np, nbad;
    reset = 1'b0; opcode = 6'd0; status = 1'b0; escritaRegIn = 1'b1;
    entradaSaidaControl = 2'b00; confirma = 1'b0; chaves = 16'd0; dadoSaida = 32'd0;

    // Reset state
    #2;
    cyc("rst", 3'd0, 1'b0, 1'b0);
    chk("rst.dadoEntrada", dadoEntrada, 32'd0);
    chk("rst.display", display, 32'd0);
    chk("rst.aguardando", 32'(aguardando), 32'd0);
    chk("rst.parado", 32'(parado), 32'd0);
    tick();
    reset = 1'b1;
    #1;

    // add: 0,1,1,0 with pulses on cycle 3, then repeats
    cyc("add1", 3'd0, 1'b0, 1'b0);
    tick(); cyc("add2", 3'd1, 1'b0, 1'b0);
    tick(); cyc("add3", 3'd1, 1'b1, 1'b1);
    tick(); cyc("add4", 3'd0, 1'b0, 1'b0);
    tick(); cyc("add5", 3'd1, 1'b0, 1'b0);
    tick(); cyc("add6", 3'd1, 1'b1, 1'b1);
    tick(); cyc("add7", 3'd0, 1'b0, 1'b0);

    // out then add: display latches at commit edge and holds
    opcode = 6'b000111; escritaRegIn = 1'b0; entradaSaidaControl = 2'b01;
    dadoSaida = 32'hDEADBEEF;
    tick(); cyc("out_e0", 3'd1, 1'b0, 1'b0);
    chk("out_e0.display", display, 32'd0);
    tick(); cyc("out_last", 3'd1, 1'b1, 1'b0);
    chk("out_last.display", display, 32'd0);
    tick(); cyc("out_busca", 3'd0, 1'b0, 1'b0);
    chk("out_busca.display", display, 32'hDEADBEEF);
    opcode = 6'd0; escritaRegIn = 1'b1; entradaSaidaControl = 2'b00;
    dadoSaida = 32'h12345678;
    tick();
    tick(); cyc("add_after_out", 3'd1, 1'b1, 1'b1);
    tick(); chk("display_hold", display, 32'hDEADBEEF);

    // in with confirm after 10 cycles in ESPERA
    opcode = 6'b011101; status = 1'b1; chaves = 16'hA5C3;
    tick();
    tick(); cyc("in_last", 3'd1, 1'b0, 1'b0);
    tick(); chk("in_espera", 32'(estado), 32'd2);
    chk("in_aguardando", 32'(aguardando), 32'd1);
    repeat (9) tick();
    cyc("in_wait", 3'd2, 1'b0, 1'b0);
    chk("in_wait.dadoEntrada", dadoEntrada, 32'd0);
    confirma = 1'b1;
    tick(); chk("in_sync1", 32'(estado), 32'd2);
    confirma = 1'b0;
    tick(); cyc("in_edge", 3'd2, 1'b0, 1'b0);
    chk("in_edge.aguardando", 32'(aguardando), 32'd1);
    tick(); cyc("in_escreve", 3'd3, 1'b1, 1'b1);
    chk("in_escreve.dadoEntrada", dadoEntrada, 32'h0000A5C3);
    chk("in_escreve.aguardando", 32'(aguardando), 32'd0);
    opcode = 6'd0; status = 1'b0;
    tick(); cyc("in_busca", 3'd0, 1'b0, 1'b0);

    // press during add execute is discarded, then pause waits for a fresh press
    tick(); confirma = 1'b1;
    tick(); cyc("disc_last", 3'd1, 1'b1, 1'b1);
    confirma = 1'b0;
    tick(); cyc("disc_busca", 3'd0, 1'b0, 1'b0);
    opcode = 6'b100000; status = 1'b1;
    tick(); cyc("pause_e0", 3'd1, 1'b0, 1'b0);
    tick(); cyc("pause_last", 3'd1, 1'b0, 1'b0);
    tick(); cyc("pausa", 3'd4, 1'b0, 1'b0);
    chk("pausa.aguardando", 32'(aguardando), 32'd1);
    repeat (3) tick();
    cyc("pausa_hold", 3'd4, 1'b0, 1'b0);
    confirma = 1'b1;
    tick(); cyc("pausa_sync1", 3'd4, 1'b0, 1'b0);
    confirma = 1'b0;
    tick(); cyc("pausa_edge", 3'd4, 1'b1, 1'b0);
    opcode = 6'd0; status = 1'b0;
    tick(); cyc("pausa_busca", 3'd0, 1'b0, 1'b0);

    // held button in ESPERA gives exactly one latch
    opcode = 6'b011101; status = 1'b1; chaves = 16'h1234;
    wait_state(3'd2, 10, "held_reach_espera");
    confirma = 1'b1;
    nw = 0; ne = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (estado == 3'd3) nw++;
      if (escritaReg) ne++;
    end
    chk("held.escreve_count", 32'(nw), 32'd1);
    chk("held.write_count", 32'(ne), 32'd1);
    chk("held.dadoEntrada", dadoEntrada, 32'h00001234);
    chk("held.estado", 32'(estado), 32'd2);
    confirma = 1'b0; opcode = 6'b011111; status = 1'b0; chaves = 16'h0F0F;
    repeat (3) tick();
    confirma = 1'b1;
    wait_state(3'd3, 10, "rel_reach_escreve");
    chk("rel.dadoEntrada", dadoEntrada, 32'h00000F0F);
    confirma = 1'b0;

    // END freezes the core
    wait_state(3'd5, 10, "end_reach_fim");
    cyc("fim", 3'd5, 1'b0, 1'b0);
    chk("fim.parado", 32'(parado), 32'd1);
    chk("fim.aguardando", 32'(aguardando), 32'd0);
    np = 0; nbad = 0;
    for (int i = 0; i < 50; i++) begin
      confirma = ((i / 3) % 2) == 1;
      tick();
      if (habilitaPC || escritaReg) np++;
      if (estado != 3'd5) nbad++;
    end
    chk("fim.pulses", 32'(np), 32'd0);
    chk("fim.left_state", 32'(nbad), 32'd0);

    // asynchronous reset out of FIM
    #1;
    reset = 1'b0;
    #1;
    cyc("arst", 3'd0, 1'b0, 1'b0);
    chk("arst.parado", 32'(parado), 32'd0);
    chk("arst.aguardando", 32'(aguardando), 32'd0);
    chk("arst.dadoEntrada", dadoEntrada, 32'd0);
    chk("arst.display", display, 32'd0);
    opcode = 6'd0; confirma = 1'b0;
    tick();
    chk("arst_hold", 32'(estado), 32'd0);
    reset = 1'b1;
    #1;
    chk("rel_busca", 32'(estado), 32'd0);
    tick();
    chk("rel_executa", 32'(estado), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
